fetch_queue: RTL and testbench

Decoupling buffer between the instruction-fetch pipeline and the dual-issue decode stage. It accepts up to two fetched instructions per cycle from fetch stage 1 and stores them in a circular queue. Each cycle it presents the oldest instructions as a `fetch_data_t [1:0]` pair on `dataF2`, withholding a control-transfer instruction until its delay slot can be presented with it. Index 1 is always the older instruction, which is the lane decode treats as the branch-capable slot.

---
 rtl/fetch_queue_pkg.sv | 36 +++
 rtl/fetch_queue_branch_predecode.sv | 15 +
 rtl/fetch_queue.sv | 94 +++++++++
 tb/tb_fetch_queue.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared CPU types for the fetch/decode boundary and the MIPS opcode constants
// used to recognise control-transfer instructions.
package fetch_queue_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pre_b;
    logic [31:0] pred_pc_jr;
  } fetch_data_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        is_ctrl;
  } decode_data_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [3:0] OP_BR_PFX  = 4'b0001;   // BEQ/BNE/BLEZ/BGTZ
  localparam logic [4:0] FN_JR_PFX  = 5'b00100;  // JR/JALR

  function automatic logic is_ctrl_transfer(input logic [31:0] instr);
    logic [5:0] op;
    logic [5:0] fn;
    op = instr[31:26];
    fn = instr[5:0];
    return (op == OP_J) || (op == OP_JAL) || (op[5:2] == OP_BR_PFX) ||
           (op == OP_REGIMM) || ((op == OP_SPECIAL) && (fn[5:1] == FN_JR_PFX));
  endfunction

endpackage

// File: rtl/fetch_queue_branch_predecode.sv
// Combinational classifier: flags instructions that own a delay slot.
module branch_predecode
  import fetch_queue_pkg::*;
(
  input  logic [31:0] raw_instr,
  output logic        is_ctrl
);

  // Only opcode and funct matter; the middle bits are deliberately ignored.
  logic unused_mid;
  assign unused_mid = ^raw_instr[25:6];

  assign is_ctrl = is_ctrl_transfer(raw_instr);

endmodule

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch stage 1 and dual-issue decode;
// holds back a control transfer until its delay slot can be presented with it.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  fetch_data_t [1:0]  dataF1,
  output logic               in_ready,
  output fetch_data_t [1:0]  dataF2,
  input  logic [1:0]         deq_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_data_t     mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;

  logic [AW-1:0]   peek_idx [2];
  fetch_data_t     peek [2];
  logic [1:0]      peek_ctrl;

  logic            lane1_valid;
  logic            lane0_valid;
  logic            push1;
  logic            push0;
  logic [1:0]      n_push;
  logic [1:0]      n_avail;
  logic [1:0]      n_pop;
  logic [AW-1:0]   wr_idx0;

  // Lane 1 reads head, lane 0 reads head+1 (wrapping naturally in AW bits).
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_peek
      assign peek_idx[gi] = head + AW'(1 - gi);
      assign peek[gi]     = mem[peek_idx[gi]];
      branch_predecode u_predecode (
        .raw_instr (peek[gi].instr),
        .is_ctrl   (peek_ctrl[gi])
      );
    end
  endgenerate

  assign lane1_valid = (count != '0) && !(peek_ctrl[1] && (count == CW'(1)));
  assign lane0_valid = (count >= CW'(2)) && lane1_valid && !peek_ctrl[0];

  always_comb begin
    dataF2[1]            = peek[1];
    dataF2[1].valid      = lane1_valid;
    dataF2[0]            = peek[0];
    dataF2[0].valid      = lane0_valid;
    dataF2[0].pre_b      = 1'b0;
    dataF2[0].pred_pc_jr = '0;
  end

  assign in_ready = (count <= CW'(DEPTH - 2));
  assign push1    = in_ready && dataF1[1].valid;
  assign push0    = in_ready && dataF1[0].valid;
  assign n_push   = {1'b0, push1} + {1'b0, push0};
  assign wr_idx0  = tail + AW'(push1);

  // Decode may not consume more than it was shown; clamp rather than corrupt.
  assign n_avail = {1'b0, lane1_valid} + {1'b0, lane0_valid};
  assign n_pop   = (deq_cnt > n_avail) ? n_avail : deq_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + AW'(n_pop);
      tail  <= tail + AW'(n_push);
      count <= count + CW'(n_push) - CW'(n_pop);
    end
  end

  // Payload storage carries no reset; validity comes solely from count.
  always_ff @(posedge clk) begin
    if (push1 && !flush) mem[tail]    <= dataF1[1];
    if (push0 && !flush) mem[wr_idx0] <= dataF1[0];
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: table-driven cycle steps with a queue
// scoreboard for presented payloads, plus a mid-stream asynchronous reset.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam logic [31:0] ADDU = 32'h00221821;
  localparam logic [31:0] BEQ  = 32'h10220004;
  localparam logic [31:0] JR   = 32'h03e00008;
  localparam logic [31:0] NOP  = 32'h00000000;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              flush = 1'b0;
  fetch_data_t [1:0] dataF1;
  logic              in_ready;
  fetch_data_t [1:0] dataF2;
  logic [1:0]        deq_cnt = 2'd0;

  fetch_queue #(.DEPTH(8)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .dataF1   (dataF1),
    .in_ready (in_ready),
    .dataF2   (dataF2),
    .deq_cnt  (deq_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v1;
    logic [31:0] pc1;
    logic [31:0] in1;
    logic        v0;
    logic [31:0] pc0;
    logic [31:0] in0;
    logic [1:0]  deq;
    logic        fl;
    logic        e_rdy;
    logic        e_v1;
    logic        e_v0;
  } step_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  step_t tbl[24];

  // Independent classifier written from the opcode map, not the package helper.
  function automatic logic tb_is_ctrl(input logic [31:0] i);
    case (i[31:26])
      6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd1: return 1'b1;
      6'd0:    return (i[5:0] == 6'h08) || (i[5:0] == 6'h09);
      default: return 1'b0;
    endcase
  endfunction

  function automatic step_t mk(input logic v1, input logic [31:0] pc1, input logic [31:0] in1,
                               input logic v0, input logic [31:0] pc0, input logic [31:0] in0,
                               input logic [1:0] deq, input logic fl,
                               input logic e_rdy, input logic e_v1, input logic e_v0);
    step_t s;
    s.v1 = v1; s.pc1 = pc1; s.in1 = in1; s.v0 = v0; s.pc0 = pc0; s.in0 = in0;
    s.deq = deq; s.fl = fl; s.e_rdy = e_rdy; s.e_v1 = e_v1; s.e_v0 = e_v0;
    return s;
  endfunction

  function automatic fetch_data_t mk_in(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    fetch_data_t d;
    d.valid = v; d.pc = pc; d.instr = instr; d.pre_b = 1'b1;
    d.pred_pc_jr = pc ^ 32'hF000_0000;
    return d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Called at a falling edge: check pre-edge outputs, drive, clock, update model.
  task automatic do_step(input int n, input step_t s);
    int   sz;
    logic mv1, mv0, mrdy;
    sz   = sb.size();
    mv1  = (sz >= 1) && !(tb_is_ctrl(sb[0].instr) && sz == 1);
    mv0  = (sz >= 2) && mv1 && !tb_is_ctrl(sb[1].instr);
    mrdy = (sz <= 6);
    $display("step %0d: push=%b%b deq=%0d flush=%b rdy=%b v=%b%b pc1=%h pc0=%h",
             n, s.v1, s.v0, s.deq, s.fl, in_ready, dataF2[1].valid, dataF2[0].valid,
             dataF2[1].pc, dataF2[0].pc);
    chk($sformatf("in_ready[%0d]", n), 32'(in_ready), 32'(s.e_rdy));
    chk($sformatf("v1[%0d]", n), 32'(dataF2[1].valid), 32'(s.e_v1));
    chk($sformatf("v0[%0d]", n), 32'(dataF2[0].valid), 32'(s.e_v0));
    if (mv1) begin
      chk($sformatf("pc1[%0d]", n), dataF2[1].pc, sb[0].pc);
      chk($sformatf("instr1[%0d]", n), dataF2[1].instr, sb[0].instr);
      chk($sformatf("pre_b1[%0d]", n), 32'(dataF2[1].pre_b), 32'd1);
      chk($sformatf("pred1[%0d]", n), dataF2[1].pred_pc_jr, sb[0].pc ^ 32'hF000_0000);
    end
    if (mv0) begin
      chk($sformatf("pc0[%0d]", n), dataF2[0].pc, sb[1].pc);
      chk($sformatf("instr0[%0d]", n), dataF2[0].instr, sb[1].instr);
      chk($sformatf("pre_b0[%0d]", n), 32'(dataF2[0].pre_b), 32'd0);
      chk($sformatf("pred0[%0d]", n), dataF2[0].pred_pc_jr, 32'd0);
    end
    chk($sformatf("deq_legal[%0d]", n), 32'(s.deq <= (2'(dataF2[1].valid) + 2'(dataF2[0].valid))), 32'd1);
    dataF1[1] = mk_in(s.v1, s.pc1, s.in1);
    dataF1[0] = mk_in(s.v0, s.pc0, s.in0);
    deq_cnt   = s.deq;
    flush     = s.fl;
    @(posedge clk);
    if (s.fl) sb.delete();
    else begin
      for (int k = 0; k < int'(s.deq) && sb.size() > 0; k++) void'(sb.pop_front());
      if (mrdy && s.v1) sb.push_back('{pc: s.pc1, instr: s.in1});
      if (mrdy && s.v0) sb.push_back('{pc: s.pc0, instr: s.in0});
    end
    @(negedge clk);
  endtask

  initial begin
    //              v1 pc1       in1   v0 pc0       in0   deq fl  rdy v1 v0
    tbl[0]  = mk(1, 32'h100, ADDU, 1, 32'h104, ADDU, 0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  0, 0, 1, 1, 1);
    tbl[2]  = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  2, 0, 1, 1, 1);
    tbl[3]  = mk(1, 32'h200, ADDU, 1, 32'h204, BEQ,  0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  0, 0, 1, 1, 0);
    tbl[5]  = mk(1, 32'h208, ADDU, 0, 32'h0,   NOP,  1, 0, 1, 1, 0);
    tbl[6]  = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  2, 0, 1, 1, 1);
    tbl[7]  = mk(0, 32'h0,   NOP,  1, 32'h300, JR,   0, 0, 1, 0, 0);
    tbl[8]  = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 32'h0,   NOP,  1, 32'h304, NOP,  0, 0, 1, 0, 0);
    tbl[10] = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  0, 0, 1, 1, 1);
    tbl[11] = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  2, 0, 1, 1, 1);
    tbl[12] = mk(1, 32'h400, ADDU, 1, 32'h404, ADDU, 0, 0, 1, 0, 0);
    tbl[13] = mk(1, 32'h408, ADDU, 1, 32'h40c, ADDU, 0, 0, 1, 1, 1);
    tbl[14] = mk(1, 32'h410, ADDU, 1, 32'h414, ADDU, 0, 0, 1, 1, 1);
    tbl[15] = mk(1, 32'h418, ADDU, 1, 32'h41c, ADDU, 0, 0, 1, 1, 1);
    tbl[16] = mk(1, 32'h420, ADDU, 1, 32'h424, ADDU, 0, 0, 0, 1, 1);
    tbl[17] = mk(1, 32'h428, ADDU, 1, 32'h42c, ADDU, 1, 0, 0, 1, 1);
    tbl[18] = mk(1, 32'h430, ADDU, 0, 32'h0,   NOP,  0, 0, 0, 1, 1);
    tbl[19] = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  2, 0, 0, 1, 1);
    tbl[20] = mk(1, 32'h500, ADDU, 1, 32'h504, ADDU, 2, 1, 1, 1, 1);
    tbl[21] = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  0, 0, 1, 0, 0);
    tbl[22] = mk(1, 32'h600, ADDU, 1, 32'h604, ADDU, 0, 0, 1, 0, 0);
    tbl[23] = mk(0, 32'h0,   NOP,  0, 32'h0,   NOP,  0, 0, 1, 1, 1);

    dataF1[1] = mk_in(0, 0, NOP);
    dataF1[0] = mk_in(0, 0, NOP);
    repeat (3) @(negedge clk);
    chk("reset_v1", 32'(dataF2[1].valid), 32'd0);
    chk("reset_v0", 32'(dataF2[0].valid), 32'd0);
    chk("reset_rdy", 32'(in_ready), 32'd1);
    resetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++) do_step(i, tbl[i]);

    // Build occupancy to 6, then pull reset mid low-phase (no clock edge).
    do_step(24, mk(1, 32'h700, ADDU, 1, 32'h704, ADDU, 0, 0, 1, 1, 1));
    do_step(25, mk(1, 32'h708, ADDU, 1, 32'h70c, ADDU, 0, 0, 1, 1, 1));
    #2 resetn = 1'b0;
    #1;
    $display("async reset: rdy=%b v=%b%b", in_ready, dataF2[1].valid, dataF2[0].valid);
    chk("async_rst_v1", 32'(dataF2[1].valid), 32'd0);
    chk("async_rst_v0", 32'(dataF2[0].valid), 32'd0);
    chk("async_rst_rdy", 32'(in_ready), 32'd1);
    sb.delete();
    dataF1[1] = mk_in(0, 0, NOP);
    dataF1[0] = mk_in(0, 0, NOP);
    deq_cnt = 2'd0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_step(26, mk(1, 32'h800, ADDU, 1, 32'h804, ADDU, 0, 0, 1, 0, 0));
    do_step(27, mk(0, 32'h0, NOP, 0, 32'h0, NOP, 2, 0, 1, 1, 1));
    do_step(28, mk(0, 32'h0, NOP, 0, 32'h0, NOP, 0, 0, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
